fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end for the word-addressed RISC-V core. It generates the PC and issues reads to a synchronous 1-cycle-latency instruction RAM. Returned words are buffered, each tagged with its PC, in a QDEPTH-entry prefetch queue, and handed to the execute stage over a valid/ready handshake. Branch, jal and jalr redirects from execute flush the queue and any in-flight read, and restart fetch at the redirect target. A configurable PC limit halts fetch for end-of-program detection.

Parameters:
PC_W, 12, width of the word-addressed PC; instruction memory depth is 2**PC_W words.
INST_W, 32, instruction width.
QDEPTH, 4, prefetch queue entries; must be a power of two and >= 2. Full throughput needs >= 3.
RESET_PC, 0, PC loaded on reset.
PC_LIMIT, 2**PC_W-1, last fetchable PC; fetch halts while pc_q > PC_LIMIT.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  reset, synchronous, active-low
imem_en  out  1  instruction RAM read strobe
imem_addr  out  PC_W  instruction RAM word address
imem_rdata  in  INST_W  RAM read data, valid the cycle after imem_en
inst_valid  out  1  queue head holds a valid instruction
inst_ready  in  1  execute stage accepts the head
inst_data  out  INST_W  head instruction
inst_pc  out  PC_W  PC of the head instruction
redirect_valid  in  1  execute requests a control-flow change
redirect_pc  in  PC_W  redirect target (word address)
halted  out  1  pc_q > PC_LIMIT, so fetch is suspended
q_count  out  $clog2(QDEPTH)+1  number of occupied queue entries

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc_q=RESET_PC, queue empty (q_count=0), inflight=0.
  - inst_valid=0, imem_en=0, halted=(RESET_PC>PC_LIMIT).
  - Reset dominates all other inputs. A RAM response arriving the cycle after reset is discarded.
- Issue condition, evaluated combinationally each cycle: issue = !redirect_valid && !halted && (q_count + inflight < QDEPTH).
  - The credit is conservative: a dequeue in the same cycle does not free a slot until the next cycle.
- On issue:
  - imem_en=1, imem_addr=pc_q.
  - At the edge: inflight<=1 and pc_q<=pc_q+1, wrapping modulo 2**PC_W.
  - The issued PC is held in an inflight_pc register.
- When not issuing: imem_en=0 and imem_addr=pc_q; the RAM ignores imem_addr.
- Response:
  - If inflight=1, the next edge writes {imem_rdata, inflight_pc} into the tail and increments q_count.
  - The queue has no bypass. Data is visible at the head the cycle after the RAM returns it.
- Dequeue:
  - inst_valid = (q_count!=0).
  - inst_valid && inst_ready pops the head at the edge.
  - A simultaneous enqueue and dequeue leaves q_count unchanged.
  - inst_data and inst_pc stay stable while inst_valid && !inst_ready.
- Queue storage is a circular buffer with rd/wr pointers that wrap modulo QDEPTH. q_count never exceeds QDEPTH; overflow is impossible by construction.
- Redirect (redirect_valid=1 at an edge):
  - q_count<=0, pointers reset, pc_q<=redirect_pc, no issue that cycle.
  - A response for a read issued in the same cycle as or before the redirect is dropped. In-flight responses are tagged with an epoch bit that toggles on every redirect; a mismatched tag is not enqueued.
  - A handshake (inst_valid && inst_ready) in the redirect cycle counts as consumed; all other entries are lost.
  - Latency: redirect at cycle T → imem_en at T+1 with address redirect_pc → inst_valid=1 with inst_pc=redirect_pc at T+3.
  - Back-to-back redirects: the last one wins.
  - Redirect has priority over the halt state. A redirect to a PC <= PC_LIMIT resumes fetch.
- Halt:
  - halted is a registered-state function of pc_q.
  - When pc_q passes PC_LIMIT, fetch stops. The queue and an in-flight response still drain normally.
- Steady state (inst_ready=1, no redirect, QDEPTH>=3): one instruction per cycle, PCs strictly consecutive.

Test Plan:
1. Reset then run: release rst_n with RAM[i]=0x1000_0000+i and inst_ready=1 → inst_valid first high 3 cycles after reset release with inst_pc=0, inst_data=0x10000000. Then pc 1,2,3… one per cycle with no gaps.
2. Backpressure: hold inst_ready=0 for 10 cycles → q_count saturates at 4, imem_en stays 0 once count+inflight=4, and the head stays pc=0. Release → pcs 0..7 are delivered in order, none lost or duplicated.
3. Redirect flush: at steady state, pulse redirect_valid with redirect_pc=0x020 while the head is pc=5 and accepted → pc=5 consumed once. Pcs 6..8 and the in-flight read never appear. inst_pc=0x020 is valid exactly 3 cycles later.
4. Double redirect: redirect to 0x010 then to 0x030 on consecutive cycles → no 0x010 instruction ever appears; the first valid inst_pc is 0x030.
5. Halt and wrap: PC_LIMIT=30, run from 0 → last inst_pc=30, halted=1, imem_en=0 thereafter. Redirect to 2 → halted=0 and fetch resumes at 2. With the default PC_LIMIT, redirect to 0xFFE → pcs 0xFFE, 0xFFF, 0x000 are delivered in sequence.
6. Reset mid-operation: assert rst_n=0 for one cycle with 3 entries queued and one read in flight → q_count=0 and inst_valid=0 the next cycle, and the stale response is not enqueued. The first output after release is pc=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction RAM, fetch-to-execute and redirect signal bundle
interface fetch_queue_unit_if #(
    parameter int PC_W   = 12,
    parameter int INST_W = 32
);
    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [PC_W-1:0]   inst_pc;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;

    modport master (
        output imem_en, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC generation, instruction RAM reads and prefetch queue with redirect flush
module fetch_queue_unit #(
    parameter int PC_W     = 12,
    parameter int INST_W   = 32,
    parameter int QDEPTH   = 4,
    parameter int RESET_PC = 0,
    parameter int PC_LIMIT = 2**PC_W - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fetch_queue_unit_if.master         bus,
    output logic                       halted,
    output logic [$clog2(QDEPTH):0]    q_count
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_W:0]   LIMIT   = (PC_W+1)'(PC_LIMIT);
    localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_PC);
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(QDEPTH);

    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   inflight_pc;
    logic              inflight;
    logic              inflight_epoch;
    logic              epoch;
    logic [INST_W-1:0] q_data [QDEPTH];
    logic [PC_W-1:0]   q_pc   [QDEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW:0]       credit_used;
    logic              issue;
    logic              enq;
    logic              deq;

    // Fetch suspends once the PC runs past the last fetchable address.
    assign halted = ({1'b0, pc_q} > LIMIT);

    // Queued entries plus the outstanding read must leave room; a same-cycle pop frees nothing yet.
    assign credit_used = {1'b0, q_count} + {{CW{1'b0}}, inflight};
    assign issue       = rst_n && !bus.redirect_valid && !halted && (credit_used < DEPTH_W);

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;

    // Responses from an older epoch belong to a discarded path.
    assign enq = inflight && (inflight_epoch == epoch);
    assign deq = bus.inst_valid && bus.inst_ready;

    assign bus.inst_valid = (q_count != '0);
    assign bus.inst_data  = q_data[rd_ptr];
    assign bus.inst_pc    = q_pc[rd_ptr];

    // Queue storage: written at the tail when a live response returns.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.redirect_valid && enq) begin
            q_data[wr_ptr] <= bus.imem_rdata;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

    // PC, in-flight read tracking, epoch and queue pointers/occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= RST_PC;
            inflight_pc    <= RST_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            q_count        <= '0;
        end else if (bus.redirect_valid) begin
            pc_q     <= bus.redirect_pc;
            inflight <= 1'b0;
            epoch    <= ~epoch;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            q_count  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc_q           <= pc_q + 1'b1;
                inflight_pc    <= pc_q;
                inflight_epoch <= epoch;
            end
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fetch_queue_unit_if #(.PC_W(12), .INST_W(32)) bus0 ();
    fetch_queue_unit_if #(.PC_W(12), .INST_W(32)) bus1 ();
    logic       halted0, halted1;
    logic [2:0] qcount0, qcount1;

    fetch_queue_unit #(.PC_W(12), .INST_W(32), .QDEPTH(4), .RESET_PC(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .halted(halted0), .q_count(qcount0)
    );
    fetch_queue_unit #(.PC_W(12), .INST_W(32), .QDEPTH(4), .RESET_PC(0), .PC_LIMIT(30)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .halted(halted1), .q_count(qcount1)
    );

    // Instruction RAMs: word at address a holds 0x1000_0000 + a, one cycle latency.
    always @(posedge clk) if (bus0.imem_en) bus0.imem_rdata <= 32'h1000_0000 + {20'd0, bus0.imem_addr};
    always @(posedge clk) if (bus1.imem_en) bus1.imem_rdata <= 32'h1000_0000 + {20'd0, bus1.imem_addr};

    function automatic logic [31:0] ram_word(input logic [11:0] pc);
        return 32'h1000_0000 + {20'd0, pc};
    endfunction

    // Per-cycle observations of both instances, taken before the rising edge.
    logic        v0, f0, en0, h0, v1, f1, en1, h1;
    logic [11:0] p0, a0, p1, a1;
    logic [31:0] d0, d1;
    logic [2:0]  qc0;

    task automatic drive(input logic rdy, input logic rv, input logic [11:0] rpc);
        bus0.inst_ready = rdy;  bus1.inst_ready = rdy;
        bus0.redirect_valid = rv;  bus1.redirect_valid = rv;
        bus0.redirect_pc = rpc;  bus1.redirect_pc = rpc;
        #1;
        v0 = bus0.inst_valid; f0 = v0 && rdy; p0 = bus0.inst_pc; d0 = bus0.inst_data;
        en0 = bus0.imem_en; a0 = bus0.imem_addr; h0 = halted0; qc0 = qcount0;
        v1 = bus1.inst_valid; f1 = v1 && rdy; p1 = bus1.inst_pc; d1 = bus1.inst_data;
        en1 = bus1.imem_en; a1 = bus1.imem_addr; h1 = halted1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 12'd0);
        drive(1'b0, 1'b0, 12'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 12'd0);
        drive(1'b1, 1'b0, 12'd0);
        n_chk++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", v0); end
        n_chk++; if (qc0 !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", qc0); end
        n_chk++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL reset_imem_en: got %0b want 0", en0); end
        n_chk++; if (h0 !== 1'b0 || h1 !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b/%0b want 0/0", h0, h1); end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 12'd0);
        n_chk++; if (en0 !== 1'b1 || a0 !== 12'd0) begin n_fail++; $display("FAIL first_issue: got en=%0b addr=%0h want en=1 addr=0", en0, a0); end
        n_chk++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL early_valid0: got %0b want 0", v0); end
        drive(1'b1, 1'b0, 12'd0);
        n_chk++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL early_valid1: got %0b want 0", v0); end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 12'd0);
            n_chk++;
            if (v0 !== 1'b1 || p0 !== 12'(i) || d0 !== ram_word(12'(i))) begin
                n_fail++; $display("FAIL stream_%0d: got v=%0b pc=%0h data=%0h want v=1 pc=%0h data=%0h", i, v0, p0, d0, i, ram_word(12'(i)));
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 12'd0);
            if (i >= 2) begin
                n_chk++; if (v0 !== 1'b1 || p0 !== 12'd0) begin n_fail++; $display("FAIL bp_head_%0d: got v=%0b pc=%0h want v=1 pc=0", i, v0, p0); end
            end
            if (i >= 5) begin
                n_chk++; if (qc0 !== 3'd4 || en0 !== 1'b0) begin n_fail++; $display("FAIL bp_full_%0d: got count=%0d en=%0b want count=4 en=0", i, qc0, en0); end
            end
        end
        got = 0;
        for (int k = 0; k < 30 && got < 8; k++) begin
            drive(1'b1, 1'b0, 12'd0);
            if (f0) begin
                n_chk++;
                if (p0 !== got[11:0] || d0 !== ram_word(got[11:0])) begin
                    n_fail++; $display("FAIL bp_drain_%0d: got pc=%0h data=%0h want pc=%0h", got, p0, d0, got);
                end
                got++;
            end
        end
        n_chk++; if (got != 8) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 8", got); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 12'd0);
        drive(1'b1, 1'b1, 12'h020);
        n_chk++; if (f0 !== 1'b1 || p0 !== 12'd5) begin n_fail++; $display("FAIL redir_consume: got fire=%0b pc=%0h want fire=1 pc=5", f0, p0); end
        n_chk++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL redir_no_issue: got en=%0b want 0", en0); end
        drive(1'b1, 1'b0, 12'd0);
        n_chk++; if (v0 !== 1'b0 || en0 !== 1'b1 || a0 !== 12'h020) begin n_fail++; $display("FAIL redir_t1: got v=%0b en=%0b addr=%0h want v=0 en=1 addr=20", v0, en0, a0); end
        drive(1'b1, 1'b0, 12'd0);
        n_chk++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL redir_t2: got v=%0b want 0", v0); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 12'd0);
            n_chk++;
            if (v0 !== 1'b1 || p0 !== 12'(12'h020 + i) || d0 !== ram_word(12'(12'h020 + i))) begin
                n_fail++; $display("FAIL redir_stream_%0d: got v=%0b pc=%0h want v=1 pc=%0h", i, v0, p0, 12'h020 + i);
            end
        end
    endtask

    task automatic test_double_redirect();
        int first_idx;
        logic [11:0] first_pc;
        logic seen_old;
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 12'd0);
        drive(1'b1, 1'b1, 12'h010);
        drive(1'b1, 1'b1, 12'h030);
        first_idx = -1; first_pc = '0; seen_old = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 12'd0);
            if (v0 && p0 == 12'h010) seen_old = 1'b1;
            if (v0 && first_idx < 0) begin first_idx = i; first_pc = p0; end
        end
        n_chk++; if (first_pc !== 12'h030 || first_idx != 2) begin n_fail++; $display("FAIL dbl_first: got pc=%0h at %0d want pc=30 at 2", first_pc, first_idx); end
        n_chk++; if (seen_old !== 1'b0) begin n_fail++; $display("FAIL dbl_stale: got old-target seen=%0b want 0", seen_old); end
    endtask

    task automatic test_halt_wrap();
        int expect_pc, last_pc, got;
        logic [11:0] wrap_exp [3];
        do_reset();
        expect_pc = 0; last_pc = -1;
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, 1'b0, 12'd0);
            if (f1) begin
                n_chk++;
                if (p1 !== expect_pc[11:0] || d1 !== ram_word(expect_pc[11:0])) begin
                    n_fail++; $display("FAIL halt_seq: got pc=%0h want pc=%0h", p1, expect_pc);
                end
                last_pc = int'(p1);
                expect_pc++;
            end
        end
        n_chk++; if (last_pc != 30) begin n_fail++; $display("FAIL halt_last_pc: got %0d want 30", last_pc); end
        n_chk++; if (h1 !== 1'b1 || en1 !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL halt_state: got halted=%0b en=%0b v=%0b want 1/0/0", h1, en1, v1); end
        drive(1'b1, 1'b1, 12'd2);
        drive(1'b1, 1'b0, 12'd0);
        n_chk++; if (h1 !== 1'b0 || en1 !== 1'b1 || a1 !== 12'd2) begin n_fail++; $display("FAIL halt_resume: got halted=%0b en=%0b addr=%0h want 0/1/2", h1, en1, a1); end
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            drive(1'b1, 1'b0, 12'd0);
            if (f1) begin
                got = 1;
                n_chk++; if (p1 !== 12'd2) begin n_fail++; $display("FAIL halt_resume_pc: got %0h want 2", p1); end
            end
        end
        n_chk++; if (got != 1) begin n_fail++; $display("FAIL halt_resume_timeout: got %0d deliveries want 1", got); end
        wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000;
        drive(1'b1, 1'b1, 12'hFFE);
        got = 0;
        for (int i = 0; i < 15 && got < 3; i++) begin
            drive(1'b1, 1'b0, 12'd0);
            if (f0) begin
                n_chk++;
                if (p0 !== wrap_exp[got] || d0 !== ram_word(wrap_exp[got])) begin
                    n_fail++; $display("FAIL wrap_%0d: got pc=%0h want pc=%0h", got, p0, wrap_exp[got]);
                end
                got++;
            end
        end
        n_chk++; if (got != 3) begin n_fail++; $display("FAIL wrap_count: got %0d want 3", got); end
    endtask

    task automatic test_reset_mid();
        int got;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 12'd0);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 12'd0);
        n_chk++; if (qc0 !== 3'd3) begin n_fail++; $display("FAIL mid_prefill: got count=%0d want 3", qc0); end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 12'd0);
        n_chk++; if (qc0 !== 3'd0 || v0 !== 1'b0) begin n_fail++; $display("FAIL mid_cleared: got count=%0d v=%0b want 0/0", qc0, v0); end
        got = 0;
        for (int i = 0; i < 12 && got < 2; i++) begin
            drive(1'b1, 1'b0, 12'd0);
            if (f0) begin
                n_chk++;
                if (p0 !== got[11:0] || d0 !== ram_word(got[11:0])) begin
                    n_fail++; $display("FAIL mid_after_%0d: got pc=%0h want pc=%0h", got, p0, got);
                end
                got++;
            end
        end
        n_chk++; if (got != 2) begin n_fail++; $display("FAIL mid_timeout: got %0d deliveries want 2", got); end
    endtask

    task automatic test_random();
        logic [11:0] exp_pc, hold_pc, rpc;
        logic [31:0] hold_d;
        logic hold, rdy, rv;
        int delivered;
        do_reset();
        exp_pc = 12'd0; hold = 1'b0; hold_pc = '0; hold_d = '0; delivered = 0;
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = 12'($urandom_range(0, 4095));
            drive(rdy, rv, rpc);
            if (hold && v0) begin
                n_chk++;
                if (p0 !== hold_pc || d0 !== hold_d) begin n_fail++; $display("FAIL rnd_stable_%0d: got pc=%0h data=%0h want pc=%0h data=%0h", i, p0, d0, hold_pc, hold_d); end
            end
            n_chk++; if (qc0 > 3'd4) begin n_fail++; $display("FAIL rnd_count_%0d: got %0d want <=4", i, qc0); end
            if (f0) begin
                n_chk++;
                if (p0 !== exp_pc || d0 !== ram_word(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_order_%0d: got pc=%0h data=%0h want pc=%0h data=%0h", i, p0, d0, exp_pc, ram_word(exp_pc));
                end
                exp_pc = exp_pc + 12'd1;
                delivered++;
            end
            if (rv) exp_pc = rpc;
            hold = v0 && !rdy && !rv;
            hold_pc = p0; hold_d = d0;
        end
        n_chk++; if (delivered < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >=100", delivered); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.inst_ready = 1'b0; bus1.inst_ready = 1'b0;
        bus0.redirect_valid = 1'b0; bus1.redirect_valid = 1'b0;
        bus0.redirect_pc = '0; bus1.redirect_pc = '0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_double_redirect();
        test_halt_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
